maze_wave_engine: RTL
=====================

Name: maze_wave_engine

Overview:
- Lee-algorithm wavefront expander. It is the initiator on the grid SRAM port: it issues reads and writes and the SRAM responds.
- It labels free cells of a GRID_W x GRID_H maze with their BFS distance from a source, working outward until it labels the target or the wave stalls.
- It sits between the router control logic (start, source, target) and the grid SRAM. Its level-held done output drives the SRAM dump trigger.

Parameters:
- DATA_WIDTH, 8, cell width; must match the SRAM.
- ADDR_WIDTH, 6, SRAM address width; requires GRID_W*GRID_H <= 2^ADDR_WIDTH.
- GRID_W, 8, columns; cell address = row*GRID_W + col.
- GRID_H, 8, rows.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  source cell.
- tgt_addr  in  ADDR_WIDTH  target cell.
- mem_address  out  ADDR_WIDTH  SRAM address.
- mem_data_in  out  DATA_WIDTH  SRAM write data.
- mem_data_out  in  DATA_WIDTH  SRAM read data, registered inside the SRAM.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  level; held until the next accepted start or rst.
- found  out  1  valid while done=1; 1 = target reached.
- path_len  out  DATA_WIDTH  valid while done=1 and found=1; steps from source to target.

Behaviour:
- Cell encoding: 0x00 free; 0xFF blocked; 0x01..0xFE wave labels, with source = 0x01.
- Reset: at a clk edge with rst=1, the FSM goes to IDLE and all outputs go to 0. SRAM contents are not touched, so partial labels from an aborted run remain. rst has priority over start.
- SRAM timing:
  - Read = 2 cycles: RD state (cs=1, we=0, address) then WAIT state (cs=0). mem_data_out is sampled at the end of WAIT.
  - Write = 1 cycle: cs=1, we=1, with address and data.
  - At most one SRAM access per cycle. mem_cs=0 in every state other than RD and WR.
- start: accepted only in IDLE. That edge clears done, found and path_len and latches src/tgt; busy=1 from the next cycle. start is ignored while busy or done.
- FSM states: IDLE, TGT_RD, TGT_WAIT, SRC_RD, SRC_WAIT, SEED_WR, SCAN_RD, SCAN_WAIT, NB_RD, NB_WAIT, NB_WR, PASS_END, DONE.
- Pre-checks:
  - If src == tgt: go to DONE with found=1, path_len=0 and no SRAM accesses.
  - Read tgt; if 0xFF, go to DONE with found=0.
  - Read src; if 0xFF, go to DONE with found=0.
  - Otherwise SEED_WR writes 0x01 to src. Then label=1, progress=0, scan address=0.
- Scan:
  - Read each cell in ascending address order.
  - If the value == label, visit neighbours in order N (addr-GRID_W), E (addr+1), S (addr+GRID_W), W (addr-1).
  - Skip a neighbour outside the grid. No row wrap: E is skipped at col GRID_W-1, W at col 0; N is skipped in row 0, S in row GRID_H-1.
- Each visited neighbour:
  - Read it. If the value is 0x00, NB_WR writes label+1 and sets progress=1.
  - If the written address == tgt: DONE with found=1, path_len=label. This takes priority over the remaining neighbours and scan.
  - Non-zero neighbours are never written.
- PASS_END (after the last cell, address GRID_W*GRID_H-1):
  - If progress=0, or label+1 == 0xFE: DONE with found=0.
  - Otherwise label++, progress=0, and rescan from address 0.
- DONE: busy=0, done=1, mem_cs=0. Stays in DONE until start, which is accepted as if in IDLE.
- Arithmetic: address arithmetic is ADDR_WIDTH wide and done after the in-grid check, so no underflow is ever used. Labels never exceed 0xFE.

Test Plan:
- 8x8 all 0x00, src=0, tgt=63 -> done=1, found=1, path_len=14, mem[63]=0x0F, mem[0]=0x01, mem[9]=0x03. No address ever has an out-of-grid neighbour access.
- Row-wrap check: empty grid, src=7, tgt=8 -> found=1, path_len=8, mem[8]=0x09. The first pass writes only address 15 (mem[15]=0x02) and address 6 (mem[6]=0x02); address 8 is not written in label-1 pass.
- tgt cell preloaded 0xFF -> found=0 within 4 cycles of start; no write ever issued (mem_we stays 0).
- Target enclosed by a 0xFF ring (tgt=27, ring cells 18,19,20,26,28,34,35,36 blocked), src=0 -> found=0 after a pass with no progress; mem[27] stays 0x00.
- src=tgt=5 -> done=1, found=1, path_len=0 within 2 cycles; mem_cs never asserted.
- Control scenarios:
  - rst asserted mid-scan -> all outputs 0 the next cycle.
  - Then start with src=0, tgt=1 on a fresh grid -> found=1, path_len=1.
  - A second start pulsed while busy -> ignored; the result is unchanged.

Source files
------------

// File: rtl/maze_mem_if.sv
// maze_mem_if: grid SRAM port, the wave engine drives it and the SRAM answers
interface maze_mem_if #(parameter int DATA_WIDTH = 8, parameter int ADDR_WIDTH = 6);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic mem_cs;
  logic mem_we;
  modport master(output mem_address, mem_data_in, mem_cs, mem_we, input mem_data_out);
  modport slave(input mem_address, mem_data_in, mem_cs, mem_we, output mem_data_out);
endinterface

// File: rtl/maze_wave_engine.sv
// maze_wave_engine: Lee wavefront expander labelling grid cells with BFS distance from a source
module maze_wave_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int GRID_W = 8,
  parameter int GRID_H = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] tgt_addr,
  maze_mem_if.master mem,
  output logic busy,
  output logic done,
  output logic found,
  output logic [DATA_WIDTH-1:0] path_len
);
  typedef enum logic [3:0] {
    IDLE, TGT_RD, TGT_WAIT, SRC_RD, SRC_WAIT, SEED_WR, SCAN_RD, SCAN_WAIT,
    NB_RD, NB_WAIT, NB_WR, PASS_END, DONE
  } state_t;
  localparam logic [ADDR_WIDTH-1:0] GW = ADDR_WIDTH'(GRID_W);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(GRID_W * GRID_H - 1);
  localparam logic [ADDR_WIDTH-1:0] A1 = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] D1 = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BLK = DATA_WIDTH'(255);
  localparam logic [DATA_WIDTH-1:0] CAP = DATA_WIDTH'(254);
  state_t state, state_n, adv_state, step_state;
  logic [ADDR_WIDTH-1:0] src, src_n, tgt, tgt_n, scan, scan_n, col, row, nb_addr, adv_scan, step_scan;
  logic [DATA_WIDTH-1:0] label, label_n, len_n;
  logic progress, progress_n, found_n;
  logic [1:0] nb, nb_n;
  logic [3:0] valid;
  logic [2:0] nxt0, nxt1;
  // lowest in-grid neighbour index at or after 'from'; 4 means none left
  function automatic logic [2:0] first_nb(input logic [3:0] v, input logic [2:0] from);
    first_nb = 3'd4;
    for (int i = 3; i >= 0; i--) if (v[i] && 3'(i) >= from) first_nb = 3'(i);
  endfunction
  assign col = scan % GW;
  assign row = scan / GW;
  assign valid = {col != '0, row != ADDR_WIDTH'(GRID_H - 1), col != GW - A1, row != '0};
  assign nb_addr = nb == 2'd0 ? scan - GW : nb == 2'd1 ? scan + A1 : nb == 2'd2 ? scan + GW : scan - A1;
  assign nxt0 = first_nb(valid, 3'd0);
  assign nxt1 = first_nb(valid, {1'b0, nb} + 3'd1);
  assign adv_state = scan == LAST ? PASS_END : SCAN_RD;
  assign adv_scan = scan == LAST ? scan : scan + A1;
  assign step_state = nxt1[2] ? adv_state : NB_RD;
  assign step_scan = nxt1[2] ? adv_scan : scan;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    src_n = src;
    tgt_n = tgt;
    scan_n = scan;
    label_n = label;
    progress_n = progress;
    nb_n = nb;
    found_n = found;
    len_n = path_len;
    mem.mem_cs = 1'b0;
    mem.mem_we = 1'b0;
    mem.mem_address = '0;
    mem.mem_data_in = '0;
    case (state)
      IDLE, DONE: if (start) begin
        src_n = src_addr;
        tgt_n = tgt_addr;
        found_n = src_addr == tgt_addr;
        len_n = '0;
        state_n = src_addr == tgt_addr ? DONE : TGT_RD;
      end
      TGT_RD: begin
        mem.mem_cs = 1'b1;
        mem.mem_address = tgt;
        state_n = TGT_WAIT;
      end
      TGT_WAIT: state_n = mem.mem_data_out == BLK ? DONE : SRC_RD;
      SRC_RD: begin
        mem.mem_cs = 1'b1;
        mem.mem_address = src;
        state_n = SRC_WAIT;
      end
      SRC_WAIT: state_n = mem.mem_data_out == BLK ? DONE : SEED_WR;
      SEED_WR: begin
        mem.mem_cs = 1'b1;
        mem.mem_we = 1'b1;
        mem.mem_address = src;
        mem.mem_data_in = D1;
        label_n = D1;
        progress_n = 1'b0;
        scan_n = '0;
        state_n = SCAN_RD;
      end
      SCAN_RD: begin
        mem.mem_cs = 1'b1;
        mem.mem_address = scan;
        state_n = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        state_n = mem.mem_data_out == label && !nxt0[2] ? NB_RD : adv_state;
        scan_n = mem.mem_data_out == label && !nxt0[2] ? scan : adv_scan;
        nb_n = nxt0[1:0];
      end
      NB_RD: begin
        mem.mem_cs = 1'b1;
        mem.mem_address = nb_addr;
        state_n = NB_WAIT;
      end
      NB_WAIT: begin
        state_n = mem.mem_data_out == '0 ? NB_WR : step_state;
        scan_n = mem.mem_data_out == '0 ? scan : step_scan;
        nb_n = mem.mem_data_out == '0 ? nb : nxt1[1:0];
      end
      NB_WR: begin
        mem.mem_cs = 1'b1;
        mem.mem_we = 1'b1;
        mem.mem_address = nb_addr;
        mem.mem_data_in = label + D1;
        progress_n = 1'b1;
        state_n = nb_addr == tgt ? DONE : step_state;
        scan_n = nb_addr == tgt ? scan : step_scan;
        nb_n = nxt1[1:0];
        found_n = nb_addr == tgt;
        len_n = nb_addr == tgt ? label : path_len;
      end
      PASS_END: begin
        state_n = !progress || label + D1 == CAP ? DONE : SCAN_RD;
        label_n = !progress || label + D1 == CAP ? label : label + D1;
        progress_n = 1'b0;
        scan_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= '0;
      tgt <= '0;
      scan <= '0;
      label <= '0;
      progress <= 1'b0;
      nb <= '0;
      found <= 1'b0;
      path_len <= '0;
    end else begin
      state <= state_n;
      src <= src_n;
      tgt <= tgt_n;
      scan <= scan_n;
      label <= label_n;
      progress <= progress_n;
      nb <= nb_n;
      found <= found_n;
      path_len <= len_n;
    end
  end
endmodule
